// File: rtl/delay_pkg.sv
// Shared types and defaults for the echo-path delay-line address generator.
// Build option: OFFSET_SLEW_EN (slewed delay changes) is consumed in delay_addr_gen.
package delay_pkg;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int unsigned ADDRESS_WIDTH_DEF = 9;
  localparam int unsigned DIV_WIDTH_DEF     = 16;

endpackage

// File: rtl/delay_addr_gen_if.sv
// Control and RAM-strobe bundle of the delay-line address generator.
// master drives run controls; slave (the generator) drives RAM strobes.
interface delay_addr_gen_if
  import delay_pkg::*;
#(
  parameter int unsigned AW = ADDRESS_WIDTH_DEF,
  parameter int unsigned DW = DIV_WIDTH_DEF
);

  logic          en;
  logic [DW-1:0] div;
  logic [AW-1:0] offset;
  logic          wr;
  logic          rd;
  logic [AW-1:0] addr1;
  logic [AW-1:0] addr0;
  logic          dout_valid;
  logic          filling;

  modport master (
    output en,
    output div,
    output offset,
    input  wr,
    input  rd,
    input  addr1,
    input  addr0,
    input  dout_valid,
    input  filling
  );

  modport slave (
    input  en,
    input  div,
    input  offset,
    output wr,
    output rd,
    output addr1,
    output addr0,
    output dout_valid,
    output filling
  );

endinterface

// File: rtl/delay_addr_gen_sample_strobe.sv
// Sample-rate divider: one-cycle tick every div+1 enabled clocks.
// A shrinking div wraps an out-of-range count to 0 without a tick.
module sample_strobe #(
  parameter int unsigned DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] cnt_q;
  logic [DIV_WIDTH-1:0] cnt_d;

  // next count and tick; disabled cycles hold the count
  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (en) begin
      if (cnt_q == div) begin
        tick  = 1'b1;
        cnt_d = '0;
      end else if (cnt_q > div) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // divider count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/delay_addr_gen.sv
// Write/read address and strobe generator for the mic echo delay-line RAM.
// Define OFFSET_SLEW_EN to ramp the delay by one sample per tick.
module delay_addr_gen
  import delay_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = ADDRESS_WIDTH_DEF,
  parameter int unsigned DIV_WIDTH     = DIV_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  delay_addr_gen_if.slave  bus
);

  localparam int unsigned AW = ADDRESS_WIDTH;
  localparam logic [AW-1:0] FILL_MAX = '1;
  localparam logic [AW-1:0] ONE = AW'(1);

  logic          tick;

  state_t        state_q;
  state_t        state_d;
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] wr_ptr_d;
  logic [AW-1:0] fill_q;
  logic [AW-1:0] fill_d;
  logic          wr_q;
  logic          wr_d;
  logic          rd_q;
  logic          rd_d;
  logic [AW-1:0] addr1_q;
  logic [AW-1:0] addr1_d;
  logic [AW-1:0] addr0_q;
  logic [AW-1:0] addr0_d;
  logic          dv_q;
  logic          dv_d;

  logic [AW-1:0] lat_nx;
  logic [AW-1:0] eff_off;

  sample_strobe #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_strobe (
    .clk (clk),
    .rst (rst),
    .en  (bus.en),
    .div (bus.div),
    .tick(tick)
  );

`ifdef OFFSET_SLEW_EN
  logic [AW-1:0] lat_q;
  logic [AW-1:0] lat_d;

  // step the latched delay one sample toward the request
  always_comb begin
    lat_nx = lat_q;
    if (bus.offset > lat_q) begin
      lat_nx = lat_q + 1'b1;
    end else if (bus.offset < lat_q) begin
      lat_nx = lat_q - 1'b1;
    end
    lat_d = tick ? lat_nx : lat_q;
  end

  // latched delay, only moves on sample ticks
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_q <= '0;
    end else begin
      lat_q <= lat_d;
    end
  end
`else
  // the request is only consumed on tick cycles, so no register is needed
  always_comb begin
    lat_nx = bus.offset;
  end
`endif

  // zero delay would read the address being written
  always_comb begin
    eff_off = (lat_nx == '0) ? ONE : lat_nx;
  end

  // per-sample pointer, fill history and FILL/RUN decisions
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    fill_d   = fill_q;
    addr1_d  = addr1_q;
    addr0_d  = addr0_q;
    wr_d     = 1'b0;
    rd_d     = 1'b0;
    dv_d     = rd_q;
    if (tick) begin
      wr_d     = 1'b1;
      addr1_d  = wr_ptr_q;
      addr0_d  = wr_ptr_q - eff_off;
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (fill_q != FILL_MAX) begin
        fill_d = fill_q + 1'b1;
      end
      unique case (state_q)
        FILL: begin
          if (fill_q >= eff_off) begin
            state_d = RUN;
            rd_d    = 1'b1;
          end
        end
        RUN: begin
          if (eff_off > fill_q) begin
            state_d = FILL;
          end else begin
            rd_d = 1'b1;
          end
        end
        default: begin
          state_d = FILL;
        end
      endcase
    end
  end

  // state, pointer and registered RAM strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= FILL;
      wr_ptr_q <= '0;
      fill_q   <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      addr1_q  <= '0;
      addr0_q  <= '0;
      dv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      fill_q   <= fill_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      addr1_q  <= addr1_d;
      addr0_q  <= addr0_d;
      dv_q     <= dv_d;
    end
  end

  // drive the RAM-side bundle
  always_comb begin
    bus.wr         = wr_q;
    bus.rd         = rd_q;
    bus.addr1      = addr1_q;
    bus.addr0      = addr0_q;
    bus.dout_valid = dv_q;
    bus.filling    = (state_q == FILL);
  end

endmodule

// File: tb/tb_delay_addr_gen.sv
// Bench for delay_addr_gen: per-cycle scoreboard against a sample-level model,
// a table of run scenarios and hand sequences for the multi-cycle corners.
module tb_delay_addr_gen;

  localparam int AW = 9;
  localparam int DW = 16;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b0;

  delay_addr_gen_if #(.AW(AW), .DW(DW)) bus ();

  delay_addr_gen #(
    .ADDRESS_WIDTH(AW),
    .DIV_WIDTH(DW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          wr;
    logic          rd;
    logic [AW-1:0] a1;
    logic [AW-1:0] a0;
    logic          dv;
    logic          fil;
  } exp_t;

  typedef struct {
    int div;
    int off;
    int nsamp;
    int first;
    int probe;
    int exp_a0;
  } vec_t;

  exp_t q[$];
  int n_tests = 0;
  int n_fail = 0;
  int sb_tests = 0;
  int sb_fail = 0;

  int m_cnt, m_ptr, m_fill, m_lat, m_a1, m_a0, m_eff;
  bit m_run, m_wr, m_rd, m_dv, m_tk;

  // reference: sample-level behaviour, expectation pushed per clock
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt = 0; m_ptr = 0; m_fill = 0; m_lat = 0;
      m_a1 = 0; m_a0 = 0; m_run = 0;
      m_wr = 0; m_rd = 0; m_dv = 0;
      q.delete();
    end else begin
      m_tk = bus.en && (m_cnt == int'(bus.div));
      if (bus.en) m_cnt = (m_cnt >= int'(bus.div)) ? 0 : m_cnt + 1;
      m_dv = m_rd;
      m_wr = 0;
      m_rd = 0;
      if (m_tk) begin
`ifdef OFFSET_SLEW_EN
        if (int'(bus.offset) > m_lat) m_lat = m_lat + 1;
        else if (int'(bus.offset) < m_lat) m_lat = m_lat - 1;
`else
        m_lat = int'(bus.offset);
`endif
        m_eff = (m_lat < 1) ? 1 : m_lat;
        m_wr = 1;
        m_a1 = m_ptr;
        m_a0 = (m_ptr + DEPTH - m_eff) % DEPTH;
        m_run = (m_fill >= m_eff);
        m_rd = m_run;
        m_fill = (m_fill < DEPTH - 1) ? m_fill + 1 : DEPTH - 1;
        m_ptr = (m_ptr + 1) % DEPTH;
      end
      q.push_back('{wr: m_wr, rd: m_rd, a1: AW'(m_a1), a0: AW'(m_a0),
                    dv: m_dv, fil: !m_run});
    end
  end

  // scoreboard compare away from the active edge
  always @(negedge clk) begin
    exp_t e;
    if (!rst && q.size() > 0) begin
      e = q.pop_front();
      sb_tests++;
      if ({bus.wr, bus.rd, bus.addr1, bus.addr0, bus.dout_valid, bus.filling}
          !== {e.wr, e.rd, e.a1, e.a0, e.dv, e.fil}) begin
        sb_fail++;
        $display("FAIL sb t=%0t got wr=%0b rd=%0b a1=%0d a0=%0d dv=%0b fil=%0b want wr=%0b rd=%0b a1=%0d a0=%0d dv=%0b fil=%0b",
                 $time, bus.wr, bus.rd, bus.addr1, bus.addr0, bus.dout_valid, bus.filling,
                 e.wr, e.rd, e.a1, e.a0, e.dv, e.fil);
      end
      if (bus.rd) begin
        sb_tests++;
        if (bus.addr0 == bus.addr1) begin
          sb_fail++;
          $display("FAIL rd_same_addr t=%0t got a0=%0d a1=%0d want different",
                   $time, bus.addr0, bus.addr1);
        end
      end
    end
  end

  task automatic chk(input string nm, input int got, input int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s got %0d want %0d", nm, got, want);
    end
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_wr"}, int'(bus.wr), 0);
    chk({nm, "_rd"}, int'(bus.rd), 0);
    chk({nm, "_dv"}, int'(bus.dout_valid), 0);
    chk({nm, "_a1"}, int'(bus.addr1), 0);
    chk({nm, "_a0"}, int'(bus.addr0), 0);
    chk({nm, "_fil"}, int'(bus.filling), 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.en = 1'b0;
    rst = 1'b1;
    #1;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
  endtask

  // negedges until the next wr pulse, bounded
  task automatic wait_wr(input int lim, output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.wr && k < lim);
  endtask

  task automatic run_case(input vec_t v);
    int seen, first, hit, lim;
    do_reset();
    bus.div = DW'(v.div);
    bus.offset = AW'(v.off);
    bus.en = 1'b1;
    seen = 0; first = -1; hit = 0;
    lim = v.nsamp * (v.div + 1) + 20;
    for (int c = 0; c < lim && seen < v.nsamp; c++) begin
      @(negedge clk);
      if (bus.wr) begin
        seen++;
        if (bus.rd && first < 0) first = int'(bus.addr1);
        if (bus.rd && int'(bus.addr1) == v.probe && hit == 0) begin
          hit = 1;
          chk("probe_a0", int'(bus.addr0), v.exp_a0);
        end
      end
    end
    chk("samples", seen, v.nsamp);
    chk("first_rd_a1", first, v.first);
    chk("probe_hit", hit, 1);
    bus.en = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    vec_t tbl[5];
    int k, seen, gap;

    tbl[0] = '{div: 3, off: 4,   nsamp: 20,  first: 4,   probe: 6,   exp_a0: 2};
    tbl[1] = '{div: 0, off: 10,  nsamp: 520, first: 10,  probe: 3,   exp_a0: 505};
    tbl[2] = '{div: 0, off: 0,   nsamp: 20,  first: 1,   probe: 5,   exp_a0: 4};
    tbl[3] = '{div: 1, off: 511, nsamp: 700, first: 511, probe: 100, exp_a0: 101};
    tbl[4] = '{div: 2, off: 1,   nsamp: 10,  first: 1,   probe: 7,   exp_a0: 6};

    bus.en = 1'b0;
    bus.div = '0;
    bus.offset = '0;
    rst = 1'b1;
    #1;
    chk_reset_outputs("por");
    #20;
    rst = 1'b0;

    for (int i = 0; i < 5; i++) run_case(tbl[i]);

    // en low for 7 cycles with the divider at count 1
    do_reset();
    bus.div = 16'd3; bus.offset = 9'd4; bus.en = 1'b1;
    wait_wr(20, k);
    @(negedge clk);
    bus.en = 1'b0;
    seen = 0;
    repeat (7) begin
      @(negedge clk);
      if (bus.wr || bus.rd) seen++;
    end
    chk("en_low_pulses", seen, 0);
    bus.en = 1'b1;
    wait_wr(20, k);
    chk("en_resume_cycles", k, 3);

    // div shrinks below the running count
    do_reset();
    bus.div = 16'd7; bus.offset = 9'd2; bus.en = 1'b1;
    wait_wr(20, k);
    repeat (5) @(negedge clk);
    bus.div = 16'd2;
    wait_wr(20, k);
    chk("div_shrink_cycles", k, 4);

    // offset raised 4 -> 50 with 20 samples of history
    do_reset();
    bus.div = 16'd0; bus.offset = 9'd4; bus.en = 1'b1;
    seen = 0;
    for (int c = 0; c < 40 && seen < 20; c++) begin
      @(negedge clk);
      if (bus.wr) seen++;
    end
    chk("pre_raise_samples", seen, 20);
    bus.offset = 9'd50;
    gap = 0;
    k = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (bus.wr && bus.rd) begin
        k = int'(bus.addr1);
        break;
      end
      if (bus.wr) gap++;
    end
`ifdef OFFSET_SLEW_EN
    chk("raise_gap", gap, 0);
    chk("raise_resume_a1", k, 20);
`else
    chk("raise_gap", gap, 30);
    chk("raise_resume_a1", k, 50);
`endif

    // async reset between edges while running
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_outputs("async");
    @(negedge clk);
    rst = 1'b0;
    wait_wr(20, k);
    chk("restart_a1", int'(bus.addr1), 0);
    chk("restart_fil", int'(bus.filling), 1);
    repeat (8) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests + sb_tests, n_fail + sb_fail);
    $finish;
  end

endmodule
